// File: rtl/dp_ram_fifo_ctrl_if.sv
// dp_ram_fifo_ctrl_if
//   Bundles the push/pop handshakes, the occupancy count and the RAM-side
//   bus of the FIFO controller.
//   slave  : the controller (consumes pushes, produces pops, drives the RAM)
//   master : the environment (producer, consumer and RAM model)
//   Signals:
//     wr_valid/wr_data/wr_ready  push handshake
//     rd_valid/rd_data/rd_ready  pop handshake
//     count                      words held, 0..DEPTH+2
//     ram_we_a/ram_addr_a/ram_din_a  RAM write port A
//     ram_we_b/ram_addr_b/ram_dout_b RAM read port B (1-cycle read latency)
interface dp_ram_fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;
  logic [ADDR_W:0]   count;
  logic              ram_we_a;
  logic [ADDR_W-1:0] ram_addr_a;
  logic [DATA_W-1:0] ram_din_a;
  logic              ram_we_b;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [DATA_W-1:0] ram_dout_b;

  modport slave (
    input  wr_valid, wr_data, rd_ready, ram_dout_b,
    output wr_ready, rd_valid, rd_data, count,
           ram_we_a, ram_addr_a, ram_din_a, ram_we_b, ram_addr_b
  );

  modport master (
    output wr_valid, wr_data, rd_ready, ram_dout_b,
    input  wr_ready, rd_valid, rd_data, count,
           ram_we_a, ram_addr_a, ram_din_a, ram_we_b, ram_addr_b
  );
endinterface

// File: rtl/dp_ram_fifo_ctrl.sv
// dp_ram_fifo_ctrl
//   Runs a 2**ADDR_W x DATA_W dual-port RAM as a synchronous FIFO. Port A
//   only writes, port B only reads. A 2-entry output queue hides the RAM's
//   1-cycle read latency so back-to-back pops sustain one word per clock.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  dp_ram_fifo_ctrl_if.slave (push/pop handshakes, count, RAM bus)
module dp_ram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  dp_ram_fifo_ctrl_if.slave   bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

  // Pointers carry one extra MSB so full (level DEPTH) differs from empty.
  logic [ADDR_W:0]   r_wptr;
  logic [ADDR_W:0]   r_rptr;
  logic              r_inflight;
  logic [1:0]        r_oq_cnt;
  logic              r_oq_head;
  logic [DATA_W-1:0] r_oq_data [2];

  logic [ADDR_W:0]   w_level;
  logic              w_push;
  logic              w_pop;
  logic              w_fetch;
  logic [2:0]        w_occ;
  logic              w_tail;

  assign w_level      = r_wptr - r_rptr;
  assign bus.wr_ready = (w_level != LVL_FULL);
  // Gated with rst so no RAM write can escape while reset is held.
  assign w_push       = bus.wr_valid & bus.wr_ready & ~rst;
  assign bus.rd_valid = (r_oq_cnt != 2'd0);
  assign w_pop        = bus.rd_valid & bus.rd_ready;

  // Queue occupancy after this cycle's pop, counting the word in flight.
  // A fetch is allowed only if its word is guaranteed a queue slot.
  assign w_occ   = {1'b0, r_oq_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_fetch = (w_level != '0) && (w_occ < 3'd2);

  // Tail slot = head + cnt (mod 2); cnt is never 2 while a word lands.
  assign w_tail = r_oq_head ^ r_oq_cnt[0];

  assign bus.rd_data    = bus.rd_valid ? r_oq_data[r_oq_head] : '0;
  assign bus.count      = w_level
                        + {{ADDR_W{1'b0}}, r_inflight}
                        + {{(ADDR_W-1){1'b0}}, r_oq_cnt};
  assign bus.ram_we_a   = w_push;
  assign bus.ram_addr_a = r_wptr[ADDR_W-1:0];
  assign bus.ram_din_a  = rst ? '0 : bus.wr_data;
  assign bus.ram_we_b   = 1'b0;
  assign bus.ram_addr_b = r_rptr[ADDR_W-1:0];

  // Fetch stage: pointers, in-flight flag and queue bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= 1'b0;
      r_oq_cnt   <= 2'd0;
      r_oq_head  <= 1'b0;
    end else begin
      if (w_push)  r_wptr <= r_wptr + 1'b1;
      if (w_fetch) r_rptr <= r_rptr + 1'b1;
      r_inflight <= w_fetch;
      if (w_pop)   r_oq_head <= ~r_oq_head;
      r_oq_cnt   <= r_oq_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  // Land stage: RAM read data enters the queue tail; data needs no reset.
  always_ff @(posedge clk) begin
    if (r_inflight) r_oq_data[w_tail] <= bus.ram_dout_b;
  end
endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// tb_dp_ram_fifo_ctrl
//   Directed bench for dp_ram_fifo_ctrl with a behavioural 16x8 RAM
//   (synchronous write on A, registered read on B) and a queue scoreboard.
module tb_dp_ram_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dp_ram_fifo_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  dp_ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (bus.ram_we_a) mem[bus.ram_addr_a] <= bus.ram_din_a;
    bus.ram_dout_b <= mem[bus.ram_addr_b];
  end

  int n_err = 0;
  int n_chk = 0;
  logic [7:0] q[$];
  logic last_push, last_pop;
  logic hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;
  int n_pop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    n_chk++;
    assert (bus.ram_we_b === 1'b0) else begin
      n_err++;
      $error("FAIL ram_we_b observed=%0h expected=0", bus.ram_we_b);
    end
  end

  // One clock cycle: drive inputs after the falling edge, check, then model.
  task automatic cyc(input logic v, input logic [7:0] d, input logic rr);
    @(negedge clk);
    bus.wr_valid = v;
    bus.wr_data  = d;
    bus.rd_ready = rr;
    #1;
    chk("count", 32'(bus.count), 32'(q.size()));
    if (hold_prev) begin
      chk("hold_valid", 32'(bus.rd_valid), 32'd1);
      chk("hold_data", 32'(bus.rd_data), 32'(hold_data));
    end
    last_push = bus.wr_valid && bus.wr_ready;
    last_pop  = bus.rd_valid && bus.rd_ready;
    chk("we_a", 32'(bus.ram_we_a), 32'(last_push));
    if (last_pop) begin
      if (q.size() == 0) chk("pop_empty", 32'd1, 32'd0 + q.size());
      else begin
        chk("pop_data", 32'(bus.rd_data), 32'(q[0]));
        void'(q.pop_front());
      end
      n_pop++;
    end
    if (last_push) q.push_back(d);
    hold_prev = bus.rd_valid && !bus.rd_ready;
    hold_data = bus.rd_data;
  endtask

  initial begin
    int acc;
    int c, first_c, last_c;
    logic [63:0] pat;
    bus.wr_valid = 1'b0;
    bus.wr_data  = 8'h00;
    bus.rd_ready = 1'b0;

    // Reset, then idle
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    #22;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      chk("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("idle_wr_ready", 32'(bus.wr_ready), 32'd1);
    end

    // Single push, latency to rd_valid
    cyc(1'b1, 8'hAA, 1'b0);
    chk("push_addr_a", 32'(bus.ram_addr_a), 32'd0);
    chk("push_din_a", 32'(bus.ram_din_a), 32'hAA);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t1_addr_b", 32'(bus.ram_addr_b), 32'd0);
    chk("t1_rd_valid", 32'(bus.rd_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t2_rd_valid", 32'(bus.rd_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t3_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("t3_rd_data", 32'(bus.rd_data), 32'hAA);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("t5_rd_valid", 32'(bus.rd_valid), 32'd0);

    // Fill to DEPTH+2, try an illegal push, drain
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b1, 8'(acc), 1'b0);
      if (last_push) acc++;
      else break;
    end
    chk("full_accepted", 32'(acc), 32'd18);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'hEE, 1'b0);
      chk("full_wr_ready", 32'(bus.wr_ready), 32'd0);
      chk("full_count", 32'(bus.count), 32'd18);
    end
    n_pop = 0;
    for (int i = 0; i < 40 && q.size() != 0; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("drain_pops", 32'(n_pop), 32'd18);
    cyc(1'b0, 8'h00, 1'b1);
    chk("drain_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("drain_pops_after", 32'(n_pop), 32'd18);

    // Streaming 40 words with rd_ready held high
    n_pop = 0; c = 0; first_c = -1; last_c = -1;
    for (int i = 0; i < 100 && n_pop < 40; i++) begin
      cyc(c < 40, 8'(c), 1'b1);
      if (c < 40) chk("stream_wr_ready", 32'(bus.wr_ready), 32'd1);
      if (last_pop) begin
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      c++;
    end
    chk("stream_pops", 32'(n_pop), 32'd40);
    chk("stream_first", 32'(first_c), 32'd3);
    chk("stream_span", 32'(last_c - first_c), 32'd39);

    // Continuous push with irregular rd_ready
    pat = 64'hB5C3_9A6E_0F17_4D2C;
    for (int i = 0; i < 64; i++) cyc(1'b1, 8'(8'h40 + i), pat[i]);
    for (int i = 0; i < 60 && q.size() != 0; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("mix_empty", 32'(q.size()), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("mix_rd_valid", 32'(bus.rd_valid), 32'd0);

    // Asynchronous reset with words held
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
    cyc(1'b1, 8'h77, 1'b0);
    chk("pre_rst_count", 32'(bus.count), 32'd5);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("arst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("arst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("arst_we_a", 32'(bus.ram_we_a), 32'd0);
    chk("arst_addr_a", 32'(bus.ram_addr_a), 32'd0);
    chk("arst_din_a", 32'(bus.ram_din_a), 32'd0);
    chk("arst_addr_b", 32'(bus.ram_addr_b), 32'd0);
    q.delete();
    hold_prev = 1'b0;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("post_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dp_ram_fifo_ctrl.md
Name: dp_ram_fifo_ctrl

Overview:
- Initiator-side controller that drives the team's 16x8 dual_port_ram as a synchronous FIFO.
- Port A of the RAM is used only for writes; port B only for reads.
- Provides valid/ready push and pop interfaces plus an occupancy count.
- Contains a 2-entry output queue so that back-to-back pops sustain one word per clock despite the RAM's 1-cycle read latency.

Parameters:
DATA_W, 8, data width; matches RAM din/dout
ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W (16) is a derived localparam

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
wr_valid  input  1  push request
wr_data  input  DATA_W  push data
wr_ready  output  1  push accepted when wr_valid && wr_ready
rd_valid  output  1  head word available
rd_data  output  DATA_W  head word
rd_ready  input  1  pop when rd_valid && rd_ready
count  output  ADDR_W+1  total words held (RAM + in-flight + output queue), 0..DEPTH+2
ram_we_a  output  1  to RAM we_a
ram_addr_a  output  ADDR_W  to RAM addr_a
ram_din_a  output  DATA_W  to RAM din_a
ram_we_b  output  1  to RAM we_b; constant 0
ram_addr_b  output  ADDR_W  to RAM addr_b
ram_dout_b  input  DATA_W  from RAM dout_b; valid the cycle after ram_addr_b is presented

Behaviour:
- State: wptr and rptr (ADDR_W+1 bits each); inflight flag; oq of 2 entries (data, head index, oq_cnt 0..2).
- Derived: ram_level = wptr - rptr, modulo 2**(ADDR_W+1), range 0..DEPTH.
- Reset (async, any time, mid-operation included):
  - wptr = rptr = 0, inflight = 0, oq_cnt = 0.
  - Outputs: wr_ready = 1, rd_valid = 0, rd_data = 0, count = 0, ram_we_a = 0, ram_addr_a = 0, ram_din_a = 0, ram_we_b = 0, ram_addr_b = 0.
  - RAM contents are not cleared and are never observable after reset.
- Push:
  - wr_ready = (ram_level < DEPTH), combinational.
  - push = wr_valid && wr_ready.
  - ram_we_a = push; ram_addr_a = wptr[ADDR_W-1:0]; ram_din_a = wr_data, all combinational.
  - wptr increments on push; wraps naturally.
- Fetch:
  - fetch = (ram_level != 0) && (oq_cnt + inflight - pop < 2).
  - ram_addr_b = rptr[ADDR_W-1:0], combinational.
  - rptr increments on fetch; inflight <= fetch.
  - A fetch may target the address written in the previous cycle; the RAM returns the new data.
- Land: when inflight = 1, ram_dout_b is written into the oq tail at the clock edge.
- Pop:
  - rd_valid = (oq_cnt != 0); rd_data = oq head entry (0 when empty).
  - pop = rd_valid && rd_ready; the head advances.
  - Land and pop in the same cycle: oq_cnt is unchanged and data order is preserved.
- count = ram_level + inflight + oq_cnt, combinational from registered state.
- Latency:
  - Push accepted in cycle t -> fetch in t+1 -> land at end of t+2 -> rd_valid in t+3.
  - Steady state with rd_ready = 1: one word per cycle in and one out.
- Full: ram_level = DEPTH -> wr_ready = 0; wr_valid is ignored with no RAM write; count can reach DEPTH+2 (18).
- Empty: count = 0 -> rd_valid = 0; rd_ready is ignored.
- Simultaneous push and fetch while ram_level = DEPTH: fetch frees a slot only at the edge, so wr_ready stays 0 that cycle (registered decision).
- Pointer wrap at 15 -> 0: the extra MSB disambiguates full from empty.
- No overflow or underflow is possible through the handshake; illegal wr_valid while full is silently dropped.

Test Plan:
- Reset then idle -> count = 0, rd_valid = 0, wr_ready = 1, ram_we_a = 0 every cycle; assert rst mid-burst with 5 words held -> all of the above within the same cycle (async).
- Push 0xAA at t, rd_ready = 0 -> rd_valid rises at t+3 with rd_data = 0xAA; count = 1 throughout; ram_addr_b = 0 at t+1.
- Push 0x00..0x11 (18 words), rd_ready = 0 -> wr_ready falls after 18 accepted; count = 18; extra push of 0xEE is not written; pop all -> 0x00..0x11 in order, no 0xEE.
- Continuous push and pop with rd_ready = 1 over 40 words (0x00..0x27) -> after 3-cycle fill, one pop per cycle; output sequence is exact across two pointer wraps.
- Random rd_ready toggling with continuous push -> no loss or duplication; count always equals pushes minus pops; rd_data holds stable while rd_valid && !rd_ready.
- ram_we_b is 0 in every cycle of every test.
